// File: rtl/bus_matrix_rr_if.sv
// Signal bundle between bus_matrix_rr, its masters and its slaves.
// The slave modport is the matrix's own view; the master modport is the surrounding system.
interface bus_matrix_rr_if #(
   parameter int nmst_p      = 3,
   parameter int nslv_p      = 2,
   parameter int addrwidth_p = 32,
   parameter int datawidth_p = 32,
   parameter int tranwidth_p = 2
);
   logic [nmst_p*tranwidth_p-1:0] mst_trans_i;
   logic [nmst_p*addrwidth_p-1:0] mst_addr_i;
   logic [nmst_p-1:0]             mst_write_i;
   logic [nmst_p*datawidth_p-1:0] mst_wdata_i;
   logic [nmst_p-1:0]             mst_ready_o;
   logic [nmst_p-1:0]             mst_resp_o;
   logic [nmst_p*datawidth_p-1:0] mst_rdata_o;
   logic [nslv_p*tranwidth_p-1:0] slv_trans_o;
   logic [nslv_p*addrwidth_p-1:0] slv_addr_o;
   logic [nslv_p-1:0]             slv_write_o;
   logic [nslv_p*datawidth_p-1:0] slv_wdata_o;
   logic [nslv_p-1:0]             slv_ready_i;
   logic [nslv_p-1:0]             slv_resp_i;
   logic [nslv_p*datawidth_p-1:0] slv_rdata_i;

   modport slave (
      input  mst_trans_i, mst_addr_i, mst_write_i, mst_wdata_i,
      input  slv_ready_i, slv_resp_i, slv_rdata_i,
      output mst_ready_o, mst_resp_o, mst_rdata_o,
      output slv_trans_o, slv_addr_o, slv_write_o, slv_wdata_o
   );

   modport master (
      output mst_trans_i, mst_addr_i, mst_write_i, mst_wdata_i,
      output slv_ready_i, slv_resp_i, slv_rdata_i,
      input  mst_ready_o, mst_resp_o, mst_rdata_o,
      input  slv_trans_o, slv_addr_o, slv_write_o, slv_wdata_o
   );
endinterface

// File: rtl/bus_matrix_rr.sv
// Masters-to-slaves matrix with per-slave round-robin grant, window decode, timeout and unmapped error.
// Grant is registered (request -> slave 1 cycle); slave ready passes straight through; waiting masters simply stall.
module bus_matrix_rr #(
   parameter int nmst_p      = 3,
   parameter int nslv_p      = 2,
   parameter int addrwidth_p = 32,
   parameter int datawidth_p = 32,
   parameter int tranwidth_p = 2,
   parameter logic [nslv_p*addrwidth_p-1:0] slv_base_p = '0,
   parameter logic [nslv_p*addrwidth_p-1:0] slv_mask_p = '0,
   parameter int timeout_p   = 0
) (
   input  logic           main_clk_i,
   input  logic           main_rst_an_i,
   bus_matrix_rr_if.slave bus
);
   localparam int mw_c = (nmst_p > 1) ? $clog2(nmst_p) : 1;
   localparam int sw_c = (nslv_p > 1) ? $clog2(nslv_p) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   logic [nmst_p-1:0] mst_req;
   logic [nmst_p-1:0] mst_mapped;
   logic [sw_c-1:0]   mst_sel [nmst_p];
   logic [nmst_p-1:0] slv_req [nslv_p];
   state_t            state_q [nslv_p];
   state_t            state_d [nslv_p];
   logic [mw_c-1:0]   gnt_q [nslv_p];
   logic [mw_c-1:0]   gnt_d [nslv_p];
   logic [mw_c-1:0]   ptr_q [nslv_p];
   logic [mw_c-1:0]   ptr_d [nslv_p];
   logic [31:0]       cnt_q [nslv_p];
   logic [31:0]       cnt_d [nslv_p];
   logic [nslv_p-1:0] tmo;
   logic [nslv_p-1:0] done;
   logic [nmst_p-1:0] err_q;

   // Descending scan so the lowest matching window index wins on overlap.
   always_comb begin
      for (int i = 0; i < nmst_p; i++) begin
         mst_req[i]    = |bus.mst_trans_i[i*tranwidth_p +: tranwidth_p];
         mst_mapped[i] = 1'b0;
         mst_sel[i]    = '0;
         for (int j = nslv_p - 1; j >= 0; j--) begin
            if ((bus.mst_addr_i[i*addrwidth_p +: addrwidth_p] & slv_mask_p[j*addrwidth_p +: addrwidth_p])
                == slv_base_p[j*addrwidth_p +: addrwidth_p]) begin
               mst_mapped[i] = 1'b1;
               mst_sel[i]    = sw_c'(j);
            end
         end
      end
   end

   always_comb begin
      for (int j = 0; j < nslv_p; j++) begin
         for (int i = 0; i < nmst_p; i++) begin
            slv_req[j][i] = mst_req[i] & mst_mapped[i] & (mst_sel[i] == sw_c'(j));
         end
         tmo[j]  = (state_q[j] == BUSY) && (timeout_p != 0) && (cnt_q[j] == 32'(timeout_p))
                   && !bus.slv_ready_i[j];
         done[j] = (state_q[j] == BUSY) && (bus.slv_ready_i[j] || tmo[j]);
      end
   end

   always_comb begin
      logic            found;
      int              idx_i;
      logic [mw_c-1:0] idx;
      found = 1'b0;
      idx_i = 0;
      idx   = '0;
      for (int j = 0; j < nslv_p; j++) begin
         state_d[j] = state_q[j];
         gnt_d[j]   = gnt_q[j];
         ptr_d[j]   = ptr_q[j];
         cnt_d[j]   = cnt_q[j];
         case (state_q[j])
            IDLE: begin
               if (|slv_req[j]) begin
                  found = 1'b0;
                  for (int k = 0; k < nmst_p; k++) begin
                     idx_i = (int'(ptr_q[j]) + k) % nmst_p;
                     idx   = mw_c'(idx_i);
                     if (!found && slv_req[j][idx]) begin
                        found    = 1'b1;
                        gnt_d[j] = idx;
                        ptr_d[j] = mw_c'((idx_i + 1) % nmst_p);
                     end
                  end
                  state_d[j] = BUSY;
                  cnt_d[j]   = 32'd1;
               end
            end
            BUSY: begin
               if (done[j]) begin
                  state_d[j] = IDLE;
                  cnt_d[j]   = '0;
               end else begin
                  cnt_d[j] = cnt_q[j] + 32'd1;
               end
            end
            default: state_d[j] = IDLE;
         endcase
      end
   end

   always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      if (!main_rst_an_i) begin
         for (int j = 0; j < nslv_p; j++) begin
            state_q[j] <= IDLE;
            gnt_q[j]   <= '0;
            ptr_q[j]   <= '0;
            cnt_q[j]   <= '0;
         end
         err_q <= '0;
      end else begin
         for (int j = 0; j < nslv_p; j++) begin
            state_q[j] <= state_d[j];
            gnt_q[j]   <= gnt_d[j];
            ptr_q[j]   <= ptr_d[j];
            cnt_q[j]   <= cnt_d[j];
         end
         // Flag lives for exactly one cycle, producing the error response.
         for (int i = 0; i < nmst_p; i++) begin
            err_q[i] <= err_q[i] ? 1'b0 : (mst_req[i] & ~mst_mapped[i]);
         end
      end
   end

   always_comb begin
      logic [nmst_p-1:0]             rdy;
      logic [nmst_p-1:0]             rsp;
      logic [nmst_p*datawidth_p-1:0] rd;
      rdy = err_q;
      rsp = err_q;
      rd  = '0;
      bus.slv_trans_o = '0;
      bus.slv_addr_o  = '0;
      bus.slv_write_o = '0;
      bus.slv_wdata_o = '0;
      for (int j = 0; j < nslv_p; j++) begin
         for (int i = 0; i < nmst_p; i++) begin
            if (state_q[j] == BUSY && gnt_q[j] == mw_c'(i)) begin
               bus.slv_trans_o[j*tranwidth_p +: tranwidth_p] = bus.mst_trans_i[i*tranwidth_p +: tranwidth_p];
               bus.slv_addr_o[j*addrwidth_p +: addrwidth_p]  = bus.mst_addr_i[i*addrwidth_p +: addrwidth_p];
               bus.slv_write_o[j]                             = bus.mst_write_i[i];
               bus.slv_wdata_o[j*datawidth_p +: datawidth_p] = bus.mst_wdata_i[i*datawidth_p +: datawidth_p];
               rdy[i] = rdy[i] | done[j];
               rsp[i] = rsp[i] | (tmo[j] ? 1'b1 : bus.slv_resp_i[j]);
               if (!tmo[j]) begin
                  rd[i*datawidth_p +: datawidth_p] = bus.slv_rdata_i[j*datawidth_p +: datawidth_p];
               end
            end
         end
      end
      bus.mst_ready_o = rdy;
      bus.mst_resp_o  = rsp;
      bus.mst_rdata_o = rd;
   end
endmodule

// File: doc/bus_matrix_rr.md
# bus_matrix_rr

Parametrised bus matrix connecting `nmst_p` masters to `nslv_p` slaves using the matrix's trans/addr/write/wdata → ready/resp/rdata protocol. Each slave port has its own round-robin arbiter, address-window decoding and a transfer timeout. Unmapped accesses receive an internal error response. It sits between CPU/DMA masters and peripheral or memory slaves inside a single `main_clk_i` domain.

## Interface
- `nmst_p`, 3: number of master ports (≥1).
- `nslv_p`, 2: number of slave ports (≥1).
- `addrwidth_p`, 32: address width.
- `datawidth_p`, 32: data width.
- `tranwidth_p`, 2: trans width; value 0 = IDLE, any nonzero value = request.
- `slv_base_p`, 0: packed `nslv_p*addrwidth_p` base addresses, slave j at slice j.
- `slv_mask_p`, 0: packed `nslv_p*addrwidth_p` masks. Slave j matches when `(addr & mask_j) == base_j`.
- `timeout_p`, 0: busy-cycle limit per transfer; 0 disables the timeout.
- `main_clk_i` in 1: clock.
- `main_rst_an_i` in 1: reset. One clock; reset is asynchronous and active-low.
- `mst_trans_i` in `nmst_p*tranwidth_p`: master request type.
- `mst_addr_i` in `nmst_p*addrwidth_p`: master address.
- `mst_write_i` in `nmst_p`: 1 = write.
- `mst_wdata_i` in `nmst_p*datawidth_p`: write data.
- `mst_ready_o` out `nmst_p`: transfer complete, one-cycle pulse.
- `mst_resp_o` out `nmst_p`: error flag, valid with ready.
- `mst_rdata_o` out `nmst_p*datawidth_p`: read data, valid with ready.
- `slv_trans_o` out `nslv_p*tranwidth_p`: forwarded trans.
- `slv_addr_o` out `nslv_p*addrwidth_p`, `slv_write_o` out `nslv_p`, `slv_wdata_o` out `nslv_p*datawidth_p`: forwarded request fields.
- `slv_ready_i` in `nslv_p`, `slv_resp_i` in `nslv_p`, `slv_rdata_i` in `nslv_p*datawidth_p`: slave response.

## Operation
- **Reset values:** all outputs are 0. Every slave is IDLE with no grant. Round-robin pointers are 0. Timeout counters are 0. Error flags are 0.
- **Decode:** each master's address is decoded combinationally. If several windows overlap, the lowest slave index wins. If no window matches, the access is unmapped.
- **Master protocol:** a master holds trans, addr, write and wdata stable from request until the cycle in which its `mst_ready_o` is 1. Changing the request earlier is a protocol violation and is not checked.
- **Per-slave FSM:**
  - IDLE → BUSY at the clock edge when at least one master requests this slave.
  - The grant goes to the first requester found searching upward from the pointer, wrapping modulo `nmst_p`.
  - On grant to master i, the pointer becomes `(i+1) mod nmst_p`.
- **In BUSY:**
  - Slave outputs equal the granted master's fields.
  - `mst_ready_o[i]`, `mst_resp_o[i]` and `mst_rdata_o[i]` combinationally follow `slv_ready_i`, `slv_resp_i` and `slv_rdata_i`.
  - BUSY → IDLE at the edge where `slv_ready_i = 1`.
- **Non-granted or IDLE outputs:** slave outputs are 0. A waiting master sees `mst_ready_o = 0` and `mst_rdata_o = 0`.
- **Timeout:** the counter increments on each BUSY cycle, starting at 1 in the first BUSY cycle.
  - If the count equals `timeout_p` and `slv_ready_i = 0`: drive `mst_ready_o = 1`, `mst_resp_o = 1`, `mst_rdata_o = 0` that cycle, and go BUSY → IDLE at the edge.
  - If `slv_ready_i = 1` in the timeout cycle, the real slave response wins.
- **Unmapped access:**
  - A per-master error flag sets at the edge where an unmapped request is present and the flag is 0.
  - The next cycle it drives `mst_ready_o = 1`, `mst_resp_o = 1`, `mst_rdata_o = 0`, and the flag clears at that edge.
- **Parallelism:** different masters may access different slaves in parallel with no interaction.
- **Reset mid-transfer:** all grants are dropped and outputs go to 0 immediately (asynchronously). The outstanding master transfer is abandoned.

## Timing
- Minimum latency: request at cycle 0 → `slv_trans_o` in cycle 1 → with a zero-wait slave, `mst_ready_o` in cycle 1.
- Slave wait states add latency one-for-one.
- One IDLE bubble cycle follows every completed transfer on a slave. Back-to-back transfers on one slave therefore issue every 2 cycles minimum.
- Error response to an unmapped access arrives exactly 1 cycle after the request.
- Timeout response arrives in BUSY cycle `timeout_p`, i.e. cycle `timeout_p` after the request.
- No combinational path from `mst_*_i` to `slv_trans_o`: grant is registered. The path `slv_ready_i` → `mst_ready_o` is combinational.

## Test plan
- **Single read:** master 0 reads 0x0000_0010 (slave 0: base 0x0, mask 0xFFFF_0000), slave ready after 2 wait cycles with rdata 0xCAFE_F00D → `mst_ready_o[0]` in cycle 3 with that rdata, resp 0.
- **Contention:** masters 0, 1 and 2 request slave 1 simultaneously; every slave transfer is 1 cycle → grants in order 0, 1, 2 with completions at cycles 1, 3, 5. A repeat burst starts at master 0 again (pointer wrapped).
- **Parallel:** master 0 → slave 0 and master 1 → slave 1 in the same cycle → both complete in cycle 1.
- **Unmapped:** master 2 writes 0xFFFF_0000 → `mst_ready_o[2] = 1`, `mst_resp_o[2] = 1` in cycle 1. No slave sees trans.
- **Timeout:** `timeout_p = 4`, slave 0 never ready → error ready/resp to the master in cycle 4, `slv_trans_o[0] = 0` in cycle 5. A further case with ready arriving in cycle 4 → real response is returned.
- **Reset mid-operation:** assert `main_rst_an_i` while slave 1 is BUSY → all outputs are 0 with no clock edge. After release, a new request is granted to master 0 first.
